hrmpp_strip_alloc_ctrl: RTL and testbench

//   Placement controller for HRMPP. Accepts one program rectangle (height, width) per request,

---
 rtl/hrmpp_strip_alloc_ctrl.sv | 159 +++++++++++++++
 tb/tb_hrmpp_strip_alloc_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hrmpp_strip_alloc_ctrl.sv
// HRMPP placement controller: first-fit search over a strip table, opening a new strip
// when nothing fits, and returning strip ID / (x, y) origin / strike count over valid/ready.
module hrmpp_strip_alloc_ctrl #(
  parameter int unsigned NUM_STRIPS = 14,
  parameter int unsigned MAX_WIDTH  = 128,
  parameter int unsigned MAX_HEIGHT = 128
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       flush_in,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [4:0] height_in,
  input  logic [4:0] width_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       placed_out,
  output logic [3:0] strip_id_out,
  output logic [7:0] occ_width_out,
  output logic [7:0] index_x_out,
  output logic [7:0] index_y_out,
  output logic [3:0] strike_out
);

  localparam int unsigned IDX_W = 4;
  localparam int unsigned CNT_W = 5;
  localparam int unsigned DIM_W = 5;
  localparam int unsigned POS_W = 8;
  localparam int unsigned CMP_W = POS_W + 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SCAN   = 3'd1,
    OPEN   = 3'd2,
    PLACE  = 3'd3,
    REJECT = 3'd4,
    OUT    = 3'd5
  } state_t;

  state_t state, state_d;

  logic [DIM_W-1:0] h_q, w_q;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] open_cnt;
  logic [POS_W-1:0] y_top;
  logic [DIM_W-1:0] strip_h   [NUM_STRIPS];
  logic [POS_W-1:0] strip_occ [NUM_STRIPS];
  logic [POS_W-1:0] strip_y   [NUM_STRIPS];

  logic accept_c, fit_c, last_c, can_open_c;
  logic [IDX_W-1:0] new_idx_c;

  // Candidate-strip evaluation; widths are compared at 9 bits so a full strip never wraps.
  always_comb begin
    accept_c   = (state == IDLE) && !flush_in && req_valid;
    new_idx_c  = open_cnt[IDX_W-1:0];
    fit_c      = ({1'b0, idx} < open_cnt) &&
                 (h_q <= strip_h[idx]) &&
                 (({1'b0, strip_occ[idx]} + CMP_W'(w_q)) <= CMP_W'(MAX_WIDTH));
    last_c     = (open_cnt == '0) || ({1'b0, idx} == (open_cnt - CNT_W'(1)));
    can_open_c = (open_cnt < CNT_W'(NUM_STRIPS)) &&
                 (({1'b0, y_top} + CMP_W'(h_q)) <= CMP_W'(MAX_HEIGHT));
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (accept_c) begin
          if ((height_in == '0) || (width_in == '0)) state_d = REJECT;
          else                                       state_d = SCAN;
        end
      end
      SCAN: begin
        if (fit_c)       state_d = PLACE;
        else if (last_c) state_d = OPEN;
      end
      OPEN:   state_d = can_open_c ? PLACE : REJECT;
      PLACE:  state_d = OUT;
      REJECT: state_d = OUT;
      OUT:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state         <= IDLE;
      req_ready     <= 1'b1;
      out_valid     <= 1'b0;
      placed_out    <= 1'b0;
      strip_id_out  <= '0;
      occ_width_out <= '0;
      index_x_out   <= '0;
      index_y_out   <= '0;
      strike_out    <= '0;
      h_q           <= '0;
      w_q           <= '0;
      idx           <= '0;
      open_cnt      <= '0;
      y_top         <= '0;
      for (int unsigned i = 0; i < NUM_STRIPS; i++) begin
        strip_h[i]   <= '0;
        strip_occ[i] <= '0;
        strip_y[i]   <= '0;
      end
    end else begin
      state     <= state_d;
      req_ready <= (state_d == IDLE);
      out_valid <= (state_d == OUT);
      case (state)
        IDLE: begin
          if (flush_in) begin
            open_cnt   <= '0;
            y_top      <= '0;
            strike_out <= '0;
            for (int unsigned i = 0; i < NUM_STRIPS; i++) begin
              strip_h[i]   <= '0;
              strip_occ[i] <= '0;
              strip_y[i]   <= '0;
            end
          end else if (accept_c) begin
            h_q <= height_in;
            w_q <= width_in;
            idx <= '0;
          end
        end
        SCAN: if (!fit_c && !last_c) idx <= idx + IDX_W'(1);
        OPEN: begin
          if (can_open_c) begin
            strip_h[new_idx_c] <= h_q;
            strip_y[new_idx_c] <= y_top;
            y_top              <= y_top + POS_W'(h_q);
            open_cnt           <= open_cnt + CNT_W'(1);
            idx                <= new_idx_c;
          end
        end
        PLACE: begin
          placed_out     <= 1'b1;
          strip_id_out   <= idx;
          index_x_out    <= strip_occ[idx];
          index_y_out    <= strip_y[idx];
          occ_width_out  <= strip_occ[idx] + POS_W'(w_q);
          strip_occ[idx] <= strip_occ[idx] + POS_W'(w_q);
        end
        REJECT: begin
          placed_out    <= 1'b0;
          strip_id_out  <= '0;
          index_x_out   <= '0;
          index_y_out   <= '0;
          occ_width_out <= '0;
          if (strike_out != 4'hF) strike_out <= strike_out + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hrmpp_strip_alloc_ctrl.sv
// Bench for hrmpp_strip_alloc_ctrl: a reference first-fit model fills a scoreboard queue
// as requests are issued; each scenario task pops and compares when the result appears.
module tb_hrmpp_strip_alloc_ctrl;

  typedef struct packed {
    logic       placed;
    logic [3:0] id;
    logic [7:0] occ;
    logic [7:0] x;
    logic [7:0] y;
    logic [3:0] strike;
  } res_t;

  logic       clk = 1'b0;
  logic       rstn, flush_in, req_valid, req_ready;
  logic [4:0] height_in, width_in;
  logic       out_valid, out_ready, placed_out;
  logic [3:0] strip_id_out, strike_out;
  logic [7:0] occ_width_out, index_x_out, index_y_out;

  int total = 0;
  int bad   = 0;
  res_t sb[$];

  int m_h[14], m_occ[14], m_y[14];
  int m_cnt, m_ytop, m_strike;

  hrmpp_strip_alloc_ctrl dut (
    .clk(clk), .rstn(rstn), .flush_in(flush_in),
    .req_valid(req_valid), .req_ready(req_ready),
    .height_in(height_in), .width_in(width_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .placed_out(placed_out), .strip_id_out(strip_id_out),
    .occ_width_out(occ_width_out), .index_x_out(index_x_out),
    .index_y_out(index_y_out), .strike_out(strike_out)
  );

  always #5 clk = ~clk;

  function automatic string fmt(input res_t r);
    return $sformatf("placed=%0d id=%0d occ=%0d x=%0d y=%0d strike=%0d",
                     r.placed, r.id, r.occ, r.x, r.y, r.strike);
  endfunction

  function automatic res_t sample();
    res_t r;
    r = '{placed_out, strip_id_out, occ_width_out, index_x_out, index_y_out, strike_out};
    return r;
  endfunction

  task automatic model_clear(input bit clr_strike);
    m_cnt  = 0;
    m_ytop = 0;
    if (clr_strike) m_strike = 0;
    for (int i = 0; i < 14; i++) begin
      m_h[i] = 0; m_occ[i] = 0; m_y[i] = 0;
    end
  endtask

  // Reference first-fit placement; pushes the expected result for the request.
  task automatic model_step(input int h, input int w);
    res_t e;
    int found;
    found = -1;
    if (h != 0 && w != 0) begin
      for (int i = 0; i < m_cnt; i++)
        if (found < 0 && h <= m_h[i] && m_occ[i] + w <= 128) found = i;
      if (found < 0 && m_cnt < 14 && m_ytop + h <= 128) begin
        m_h[m_cnt] = h;
        m_y[m_cnt] = m_ytop;
        m_ytop += h;
        found = m_cnt;
        m_cnt++;
      end
    end
    if (found >= 0) begin
      e.placed = 1'b1;
      e.id     = 4'(found);
      e.x      = 8'(m_occ[found]);
      m_occ[found] += w;
      e.occ    = 8'(m_occ[found]);
      e.y      = 8'(m_y[found]);
      e.strike = 4'(m_strike);
    end else begin
      if (m_strike < 15) m_strike++;
      e = '0;
      e.strike = 4'(m_strike);
    end
    sb.push_back(e);
  endtask

  // Issue one request and wait for its result; leaves the bench on the out_valid negedge.
  task automatic send(input int h, input int w, output res_t got, output int lat);
    int n;
    model_step(h, w);
    n = 0;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    if (!req_ready) begin
      total++; bad++;
      $display("FAIL req_ready_timeout got=%0d want=1", req_ready);
    end
    height_in = 5'(h);
    width_in  = 5'(w);
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin @(negedge clk); lat++; end
    if (!out_valid) begin
      total++; bad++;
      $display("FAIL out_valid_timeout got=%0d want=1", out_valid);
    end
    lat = lat - 1;
    got = sample();
  endtask

  task automatic do_flush();
    while (!req_ready) @(negedge clk);
    flush_in = 1'b1;
    @(negedge clk);
    flush_in = 1'b0;
    model_clear(1'b1);
  endtask

  task automatic test_reset();
    res_t got;
    got = sample();
    total++;
    if (got !== res_t'('0) || req_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_state got %s rdy=%0d vld=%0d want all zero rdy=1 vld=0",
               fmt(got), req_ready, out_valid);
    end
  endtask

  task automatic test_first_fit();
    res_t got, exp;
    int lat;
    int hs[3] = '{4, 3, 6};
    int ws[3] = '{10, 20, 5};
    for (int i = 0; i < 3; i++) begin
      send(hs[i], ws[i], got, lat);
      exp = sb.pop_front();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL first_fit[%0d] got %s want %s", i, fmt(got), fmt(exp));
      end
      if (i == 0) begin
        total++;
        if (lat != 3) begin
          bad++;
          $display("FAIL first_open_latency got=%0d want=3", lat);
        end
      end
    end
  endtask

  task automatic test_exact_width();
    res_t got, exp;
    int lat;
    do_flush();
    for (int i = 0; i < 4; i++) begin
      send(4, 30, got, lat);
      exp = sb.pop_front();
      total++;
      if (got !== exp) begin bad++; $display("FAIL fill[%0d] got %s want %s", i, fmt(got), fmt(exp)); end
    end
    send(2, 8, got, lat);
    exp = sb.pop_front();
    total++;
    if (got !== exp) begin bad++; $display("FAIL exact_width got %s want %s", fmt(got), fmt(exp)); end
    send(1, 1, got, lat);
    exp = sb.pop_front();
    total++;
    if (got !== exp) begin bad++; $display("FAIL full_opens_new got %s want %s", fmt(got), fmt(exp)); end
  endtask

  task automatic test_strike();
    res_t got, exp;
    int lat;
    do_flush();
    for (int i = 1; i <= 14; i++) begin
      send(i, 3, got, lat);
      exp = sb.pop_front();
      total++;
      if (got !== exp) begin bad++; $display("FAIL open_strip[%0d] got %s want %s", i, fmt(got), fmt(exp)); end
    end
    for (int i = 0; i < 17; i++) begin
      send(15, 1, got, lat);
      exp = sb.pop_front();
      total++;
      if (got !== exp) begin bad++; $display("FAIL strike[%0d] got %s want %s", i, fmt(got), fmt(exp)); end
    end
  endtask

  task automatic test_height_and_zero();
    res_t got, exp;
    int lat;
    do_flush();
    for (int i = 0; i < 16; i++) begin
      send(31, 31, got, lat);
      exp = sb.pop_front();
      total++;
      if (got !== exp) begin bad++; $display("FAIL tall[%0d] got %s want %s", i, fmt(got), fmt(exp)); end
    end
    send(2, 31, got, lat);
    exp = sb.pop_front();
    total++;
    if (got !== exp) begin bad++; $display("FAIL ytop126 got %s want %s", fmt(got), fmt(exp)); end
    send(5, 31, got, lat);
    exp = sb.pop_front();
    total++;
    if (got !== exp) begin bad++; $display("FAIL height_reject got %s want %s", fmt(got), fmt(exp)); end
    do_flush();
    send(0, 5, got, lat);
    exp = sb.pop_front();
    total++;
    if (got !== exp) begin bad++; $display("FAIL zero_h got %s want %s", fmt(got), fmt(exp)); end
    send(5, 0, got, lat);
    exp = sb.pop_front();
    total++;
    if (got !== exp) begin bad++; $display("FAIL zero_w got %s want %s", fmt(got), fmt(exp)); end
    send(4, 10, got, lat);
    exp = sb.pop_front();
    total++;
    if (got !== exp) begin bad++; $display("FAIL after_zero got %s want %s", fmt(got), fmt(exp)); end
  endtask

  task automatic test_back_pressure();
    res_t got, exp, now;
    int lat;
    while (!req_ready) @(negedge clk);
    out_ready = 1'b0;
    send(3, 7, got, lat);
    exp = sb.pop_front();
    total++;
    if (got !== exp) begin bad++; $display("FAIL bp_result got %s want %s", fmt(got), fmt(exp)); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      now = sample();
      total++;
      if (now !== exp || out_valid !== 1'b1 || req_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold[%0d] got %s vld=%0d rdy=%0d want %s vld=1 rdy=0",
                 c, fmt(now), out_valid, req_ready, fmt(exp));
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release got vld=%0d rdy=%0d want vld=0 rdy=1", out_valid, req_ready);
    end
  endtask

  task automatic test_reset_mid_scan();
    res_t got, exp;
    int lat;
    do_flush();
    for (int i = 1; i <= 3; i++) begin
      send(i, 1, got, lat);
      exp = sb.pop_front();
      total++;
      if (got !== exp) begin bad++; $display("FAIL pre_scan[%0d] got %s want %s", i, fmt(got), fmt(exp)); end
    end
    send(0, 1, got, lat);
    exp = sb.pop_front();
    total++;
    if (got !== exp) begin bad++; $display("FAIL pre_strike got %s want %s", fmt(got), fmt(exp)); end
    while (!req_ready) @(negedge clk);
    height_in = 5'd3;
    width_in  = 5'd1;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    model_clear(1'b1);
    got = sample();
    total++;
    if (got !== res_t'('0) || req_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset got %s rdy=%0d vld=%0d want all zero rdy=1 vld=0",
               fmt(got), req_ready, out_valid);
    end
    send(4, 10, got, lat);
    exp = sb.pop_front();
    total++;
    if (got !== exp) begin bad++; $display("FAIL table_cleared got %s want %s", fmt(got), fmt(exp)); end
  endtask

  initial begin
    rstn      = 1'b0;
    flush_in  = 1'b0;
    req_valid = 1'b0;
    height_in = '0;
    width_in  = '0;
    out_ready = 1'b1;
    model_clear(1'b1);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    test_reset();
    test_first_fit();
    test_exact_width();
    test_strike();
    test_height_and_zero();
    test_back_pressure();
    test_reset_mid_scan();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
